// File: rtl/apb_rr_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_master
// Description : Round-robin APB master sharing one APB slave between
//               NUM_REQ requesters. Each grant runs one SETUP/ACCESS
//               transfer with a bounded pready wait. Misaligned or
//               out-of-range addresses are rejected without an APB transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_master #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_LIMIT     = 32
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0]      req_write,
   input  logic [NUM_REQ*32-1:0]   req_addr,
   input  logic [NUM_REQ*32-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]      req_ack,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [31:0]             rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   output logic [31:0]             paddr,
   output logic [31:0]             pwdata,
   output logic                    pwrite,
   output logic                    psel,
   output logic                    penable,
   input  logic                    pready,
   input  logic                    pslverr,
   input  logic [31:0]             prdata
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   cur_idx;
   logic [IW-1:0]   gnt_idx;
   logic [IW-1:0]   cand;
   logic            gnt_found;
   logic [31:0]     sel_addr;
   logic [31:0]     sel_wdata;
   logic            sel_write;
   logic            sel_reject;
   logic [CW-1:0]   tmo_cnt;
   logic            tmo_hit;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   // Round-robin search: first valid requester strictly after rr_ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Mux the granted requester's fields and decide on local rejection.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == IW'(i)) begin
            sel_addr  = req_addr[32*i +: 32];
            sel_wdata = req_wdata[32*i +: 32];
            sel_write = req_write[i];
         end
      end
      sel_reject = (sel_addr >= 32'(ADDR_LIMIT)) || (sel_addr[1:0] != 2'b00);
   end

   assign tmo_hit = (tmo_cnt == TMO_LAST);

   // Next-state logic and the combinational accept pulse.
   always_comb begin
      state_nx = state;
      req_ack  = '0;
      case (state)
         IDLE: begin
            if (gnt_found && !preset) begin
               req_ack  = onehot(gnt_idx);
               state_nx = sel_reject ? RESP : SETUP;
            end
         end
         SETUP:   state_nx = ACCESS;
         ACCESS:  if (pready || tmo_hit) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State, latched request, registered APB outputs and response registers.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state       <= IDLE;
         rr_ptr      <= LAST_IDX;
         cur_idx     <= '0;
         tmo_cnt     <= '0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state     <= state_nx;
         psel      <= (state_nx == SETUP) || (state_nx == ACCESS);
         penable   <= (state_nx == ACCESS);
         rsp_valid <= '0;
         // Counter runs only while ACCESS persists; first ACCESS cycle sees 0.
         tmo_cnt   <= (state == ACCESS && state_nx == ACCESS) ? tmo_cnt + CW'(1) : '0;

         if (state == IDLE && gnt_found) begin
            rr_ptr  <= gnt_idx;
            cur_idx <= gnt_idx;
            if (sel_reject) begin
               // Rejected locally: APB bus keeps its previous address/data.
               rsp_valid   <= onehot(gnt_idx);
               rsp_rdata   <= '0;
               rsp_err     <= 1'b1;
               rsp_timeout <= 1'b0;
            end else begin
               paddr  <= sel_addr;
               pwdata <= sel_wdata;
               pwrite <= sel_write;
            end
         end

         if (state == ACCESS && state_nx == RESP) begin
            rsp_valid <= onehot(cur_idx);
            if (pready) begin
               rsp_rdata   <= pwrite ? 32'h0 : prdata;
               rsp_err     <= pslverr;
               rsp_timeout <= 1'b0;
            end else begin
               rsp_rdata   <= '0;
               rsp_err     <= 1'b1;
               rsp_timeout <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin APB master that shares the single APB register slave (ctl_reg / timer_0 / timer_1 block) between NUM_REQ internal requesters.
- Accepts one word read/write per grant and sequences the APB SETUP/ACCESS phases.
- Waits on pready, with a bounded timeout.
- Returns read data and error status to the winning requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT_CYCLES, 16, max ACCESS-phase cycles without pready before abort (>=4)
- ADDR_LIMIT, 32, addresses >= this are rejected locally without an APB transfer

Ports:
- pclk  in  1  clock
- preset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*32  packed byte addresses, requester i at [32i+31:32i]
- req_wdata  in  NUM_REQ*32  packed write data
- req_ack  out  NUM_REQ  one-hot, 1-cycle accept pulse
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse
- rsp_rdata  out  32  read data, valid with rsp_valid
- rsp_err  out  1  pslverr seen, local reject, or timeout; valid with rsp_valid
- rsp_timeout  out  1  error was a timeout; valid with rsp_valid
- paddr  out  32  APB address
- pwdata  out  32  APB write data
- pwrite  out  1  APB direction
- psel  out  1  APB select
- penable  out  1  APB enable
- pready  in  1  APB slave ready
- pslverr  in  1  APB slave error
- prdata  in  32  APB read data

Behaviour:
- Reset (preset=1 at a pclk edge):
  - state=IDLE; rr pointer = NUM_REQ-1, so requester 0 wins first; timeout counter = 0.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0.
  - req_ack = 0 during reset.
- Reset mid-transfer: transfer is discarded, no rsp_valid is issued, psel drops on the next cycle.
- FSM states:
  - IDLE (psel=0). If any req_valid, grant the first valid index after the rr pointer, wrapping. req_ack[g]=1 combinationally in this cycle. Latch addr, wdata, write and g; rr pointer := g.
    - Latched addr >= ADDR_LIMIT or addr[1:0] != 0: go to RESP with err=1, rdata=0; no APB activity.
    - Otherwise: go to SETUP.
    - No req_valid: stay in IDLE.
  - SETUP: psel=1, penable=0, paddr/pwdata/pwrite stable. Unconditionally go to ACCESS. pready is ignored here.
  - ACCESS: psel=1, penable=1, and the timeout counter increments every cycle.
    - pready=1: capture prdata (reads only; writes return 0) and pslverr; go to RESP.
    - Counter reaches TIMEOUT_CYCLES and pready=0: err=1, timeout=1, rdata=0; go to RESP.
    - pready and timeout in the same cycle: pready wins, no timeout.
  - RESP: psel=0, penable=0; rsp_valid[g]=1 for exactly one cycle with rdata/err/timeout; counter cleared. Go to IDLE.
- Guaranteed idle gap: at least two psel=0 cycles (RESP + IDLE) between transfers, so the slave's post-transfer state drains.
- APB outputs are registered. paddr/pwdata/pwrite hold their last value while idle.
- req_* inputs are sampled only in the IDLE grant cycle. A requester must hold req_valid and its fields until it sees req_ack.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 other transfers.
- A requester that drops req_valid before it is acked is simply skipped.

Test Plan:
- Single read: req 0 reads addr 0x4 after reset -> psel rises 1 cycle after ack; penable follows 1 cycle later; rsp_valid[0] with rsp_rdata=0xCAFE1234, rsp_err=0.
- Write then read: req 1 writes 0x0000000A to addr 0x0, then reads 0x0 -> rsp_rdata=0x0000000A. psel low >= 2 cycles between the two transfers.
- Contention: req0 and req1 valid continuously, each doing 4 reads of 0x8 -> grant order 0,1,0,1,0,1,0,1; every rsp_rdata=0xFACE5678.
- Local reject: req 0 addr 0x24 and a separate req with addr 0x6 -> each gives rsp_err=1, rsp_timeout=0, rdata=0; psel never asserted.
- Timeout: slave model holds pready=0 -> rsp_err=1 and rsp_timeout=1 after exactly 16 ACCESS cycles; next transfer proceeds normally.
- Reset mid-ACCESS: assert preset for 1 cycle during ACCESS -> psel=penable=0 next cycle; no rsp_valid; the next request is granted to requester 0.
